inv_mixcolumns_seq: RTL and testbench

Iterative AES InvMixColumns engine for the decryption datapath. It is the inverse of the forward MixColumns stage built on xtime-style GF(2^8) multiplies. It accepts a 128-bit state over a valid/ready handshake and transforms COLS_PER_CYCLE columns per clock. It returns the result over a second valid/ready handshake and sits between InvShiftRows/InvSubBytes/AddRoundKey in the inverse cipher round.

---
 rtl/aes_pkg.sv | 33 +++
 rtl/inv_mixcolumns_seq_if.sv | 19 +
 rtl/inv_mixcolumn_col.sv | 14 +
 rtl/inv_mixcolumns_seq.sv | 80 ++++++++
 tb/tb_inv_mixcolumns_seq.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, InvMixColumns constants and GF(2^8) helpers
package aes_pkg;

    localparam logic [7:0] GF_POLY = 8'h1B;
    localparam logic [7:0] INV_C0  = 8'h0E;
    localparam logic [7:0] INV_C1  = 8'h0B;
    localparam logic [7:0] INV_C2  = 8'h0D;
    localparam logic [7:0] INV_C3  = 8'h09;

    typedef logic [31:0]  column_t;
    typedef logic [127:0] state_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } fsm_state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
    endfunction

    // Coefficients never exceed 4 bits, so x, x^2 and x^3 terms cover every product
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] c);
        logic [7:0] x1, x2, x3;
        x1 = xtime(a);
        x2 = xtime(x1);
        x3 = xtime(x2);
        return (c[0] ? a  : 8'h00) ^ (c[1] ? x1 : 8'h00) ^
               (c[2] ? x2 : 8'h00) ^ (c[3] ? x3 : 8'h00);
    endfunction

endpackage

// File: rtl/inv_mixcolumns_seq_if.sv
// rtl/inv_mixcolumns_seq_if.sv - input/output state handshake bundle
interface inv_mixcolumns_seq_if import aes_pkg::*; ();
    logic   in_valid;
    logic   in_ready;
    state_t in_data;
    logic   out_valid;
    logic   out_ready;
    state_t out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/inv_mixcolumn_col.sv
// rtl/inv_mixcolumn_col.sv - combinational InvMixColumns on one 32-bit column
module inv_mixcolumn_col import aes_pkg::*; (
    input  column_t col_in,
    output column_t col_out
);
    logic [7:0] a0, a1, a2, a3;

    assign {a0, a1, a2, a3} = col_in;

    assign col_out[31:24] = gf_mul(a0, INV_C0) ^ gf_mul(a1, INV_C1) ^ gf_mul(a2, INV_C2) ^ gf_mul(a3, INV_C3);
    assign col_out[23:16] = gf_mul(a0, INV_C3) ^ gf_mul(a1, INV_C0) ^ gf_mul(a2, INV_C1) ^ gf_mul(a3, INV_C2);
    assign col_out[15:8]  = gf_mul(a0, INV_C2) ^ gf_mul(a1, INV_C3) ^ gf_mul(a2, INV_C0) ^ gf_mul(a3, INV_C1);
    assign col_out[7:0]   = gf_mul(a0, INV_C1) ^ gf_mul(a1, INV_C2) ^ gf_mul(a2, INV_C3) ^ gf_mul(a3, INV_C0);
endmodule

// File: rtl/inv_mixcolumns_seq.sv
// rtl/inv_mixcolumns_seq.sv - iterative InvMixColumns, COLS_PER_CYCLE columns per clock
module inv_mixcolumns_seq import aes_pkg::*; #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    inv_mixcolumns_seq_if.slave  bus
);
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
        $error("inv_mixcolumns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    localparam int         NCYC = 4 / COLS_PER_CYCLE;
    localparam logic [1:0] LAST = 2'(NCYC - 1);

    fsm_state_t       state, state_next;
    logic [1:0]       cnt, cnt_next;
    // work[3] holds column 0 so the packed layout matches FIPS-197 byte order
    column_t [3:0]    work, work_next;

    logic [1:0]       sel     [COLS_PER_CYCLE];
    column_t          col_out [COLS_PER_CYCLE];

    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
        assign sel[g] = cnt * 2'(COLS_PER_CYCLE) + 2'(g);

        inv_mixcolumn_col u_col (
            .col_in  (work[~sel[g]]),
            .col_out (col_out[g])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 2'd0;
            work  <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            work  <= work_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        work_next  = work;
        unique case (state)
            IDLE: begin
                if (bus.in_valid && bus.in_ready) begin
                    work_next  = bus.in_data;
                    cnt_next   = 2'd0;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                for (int i = 0; i < COLS_PER_CYCLE; i++) begin
                    work_next[~sel[i]] = col_out[i];
                end
                if (cnt == LAST) begin
                    cnt_next   = 2'd0;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt + 2'd1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.in_ready  = (state == IDLE) && !reset;
    assign bus.out_valid = (state == DONE);
    assign bus.out_data  = work;
endmodule

// File: tb/tb_inv_mixcolumns_seq.sv
// tb/tb_inv_mixcolumns_seq.sv - self-checking bench for inv_mixcolumns_seq at 1, 2 and 4 columns/cycle
module tb_inv_mixcolumns_seq;
    import aes_pkg::*;

    logic   clk = 1'b0;
    logic   reset = 1'b1;
    logic   in_valid = 1'b0;
    logic   out_ready = 1'b0;
    state_t in_data = '0;

    always #5 clk = ~clk;

    inv_mixcolumns_seq_if ifc1 ();
    inv_mixcolumns_seq_if ifc2 ();
    inv_mixcolumns_seq_if ifc4 ();

    assign ifc1.in_valid = in_valid;  assign ifc1.in_data = in_data;  assign ifc1.out_ready = out_ready;
    assign ifc2.in_valid = in_valid;  assign ifc2.in_data = in_data;  assign ifc2.out_ready = out_ready;
    assign ifc4.in_valid = in_valid;  assign ifc4.in_data = in_data;  assign ifc4.out_ready = out_ready;

    inv_mixcolumns_seq #(.COLS_PER_CYCLE(1)) dut1 (.clk(clk), .reset(reset), .bus(ifc1.slave));
    inv_mixcolumns_seq #(.COLS_PER_CYCLE(2)) dut2 (.clk(clk), .reset(reset), .bus(ifc2.slave));
    inv_mixcolumns_seq #(.COLS_PER_CYCLE(4)) dut4 (.clk(clk), .reset(reset), .bus(ifc4.slave));

    logic   ov [3];
    logic   ir [3];
    state_t od [3];

    assign ov[0] = ifc1.out_valid;  assign ir[0] = ifc1.in_ready;  assign od[0] = ifc1.out_data;
    assign ov[1] = ifc2.out_valid;  assign ir[1] = ifc2.in_ready;  assign od[1] = ifc2.out_data;
    assign ov[2] = ifc4.out_valid;  assign ir[2] = ifc4.in_ready;  assign od[2] = ifc4.out_data;

    int checks = 0;
    int failures = 0;
    int lat_exp [3] = '{4, 2, 1};
    int cpc_of  [3] = '{1, 2, 4};

    typedef struct {
        state_t din;
        state_t exp;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] mul2(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic state_t fwd_mix(input state_t s);
        state_t r;
        for (int c = 0; c < 4; c++) begin
            logic [7:0] a0, a1, a2, a3;
            {a0, a1, a2, a3} = s[127-32*c -: 32];
            r[127-32*c -: 32] = {
                mul2(a0) ^ mul2(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ mul2(a1) ^ mul2(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ mul2(a2) ^ mul2(a3) ^ a3,
                mul2(a0) ^ a0 ^ a1 ^ a2 ^ mul2(a3)
            };
        end
        return r;
    endfunction

    // Transfer one state into all three DUTs together and wait for each to report done
    task automatic run(input state_t din, input state_t exp, input string tag, input bit chk_lat);
        int lat [3];
        lat = '{0, 0, 0};
        @(negedge clk);
        for (int d = 0; d < 3; d++)
            check($sformatf("%s_in_ready_c%0d", tag, cpc_of[d]), 128'(ir[d]), 128'(1));
        in_data  = din;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 3; d++)
                if (ov[d] && lat[d] == 0) lat[d] = c;
            if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0) break;
        end
        for (int d = 0; d < 3; d++) begin
            if (chk_lat)
                check($sformatf("%s_latency_c%0d", tag, cpc_of[d]), 128'(lat[d]), 128'(lat_exp[d]));
            check($sformatf("%s_data_c%0d", tag, cpc_of[d]), od[d], exp);
        end
    endtask

    task automatic drain(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("%s_drain_valid_c%0d", tag, cpc_of[d]), 128'(ov[d]), 128'(0));
            check($sformatf("%s_drain_ready_c%0d", tag, cpc_of[d]), 128'(ir[d]), 128'(1));
        end
    endtask

    initial begin
        state_t a, b, x;
        bit     stable [3];
        state_t held   [3];

        vecs[0] = '{128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 128'hdb135345_f20a225c_01010101_c6c6c6c6};
        vecs[1] = '{128'hd5d5d7d6_d5d5d7d6_d5d5d7d6_d5d5d7d6, 128'hd4d4d4d5_d4d4d4d5_d4d4d4d5_d4d4d4d5};
        vecs[2] = '{128'h4d7ebdf8_4d7ebdf8_4d7ebdf8_4d7ebdf8, 128'h2d26314c_2d26314c_2d26314c_2d26314c};
        vecs[3] = '{128'hd5d5d7d6_4d7ebdf8_d5d5d7d6_4d7ebdf8, 128'hd4d4d4d5_2d26314c_d4d4d4d5_2d26314c};
        vecs[4] = '{128'h4d7ebdf8_d5d5d7d6_8e4da1bc_9fdc589d, 128'h2d26314c_d4d4d4d5_db135345_f20a225c};
        vecs[5] = '{128'h0, 128'h0};
        vecs[6] = '{128'hffffffff_ffffffff_ffffffff_ffffffff, 128'hffffffff_ffffffff_ffffffff_ffffffff};

        // Reset state
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst_valid_c%0d", cpc_of[d]), 128'(ov[d]), 128'(0));
            check($sformatf("rst_data_c%0d", cpc_of[d]), od[d], 128'h0);
            check($sformatf("rst_in_ready_c%0d", cpc_of[d]), 128'(ir[d]), 128'(0));
        end
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run(vecs[i].din, vecs[i].exp, $sformatf("vec%0d", i), 1'b1);
            drain($sformatf("vec%0d", i));
        end

        // Backpressure: hold DONE for 10 cycles
        run(vecs[0].din, vecs[0].exp, "bp", 1'b1);
        for (int d = 0; d < 3; d++) begin
            stable[d] = 1'b1;
            held[d]   = od[d];
        end
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 3; d++)
                if (!ov[d] || ir[d] || od[d] !== held[d]) stable[d] = 1'b0;
        end
        for (int d = 0; d < 3; d++) begin
            check($sformatf("bp_stable_c%0d", cpc_of[d]), 128'(stable[d]), 128'(1));
            check($sformatf("bp_data_c%0d", cpc_of[d]), od[d], vecs[0].exp);
        end
        drain("bp");

        // A second state offered while busy must be ignored
        a = vecs[1].din;
        b = vecs[2].din;
        @(negedge clk);
        in_data  = a;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_data = b;
        @(posedge clk);
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int c = 0; c < 4; c++) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("busy_in_valid_ov_c%0d", cpc_of[d]), 128'(ov[d]), 128'(1));
            check($sformatf("busy_in_valid_data_c%0d", cpc_of[d]), od[d], vecs[1].exp);
        end
        drain("busy_in_valid");

        // Reset after column 1 of the single-column engine
        @(negedge clk);
        in_data  = vecs[0].din;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        for (int d = 0; d < 3; d++)
            check($sformatf("midrst_in_ready_c%0d", cpc_of[d]), 128'(ir[d]), 128'(0));
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("midrst_valid_c%0d", cpc_of[d]), 128'(ov[d]), 128'(0));
            check($sformatf("midrst_data_c%0d", cpc_of[d]), od[d], 128'h0);
            check($sformatf("midrst_ready_c%0d", cpc_of[d]), 128'(ir[d]), 128'(1));
        end
        run(vecs[4].din, vecs[4].exp, "post_rst", 1'b1);
        drain("post_rst");

        // Round trip against a forward MixColumns model
        for (int n = 0; n < 1000; n++) begin
            x = {$urandom, $urandom, $urandom, $urandom};
            run(fwd_mix(x), x, $sformatf("rt%0d", n), 1'b0);
            drain($sformatf("rt%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end
endmodule
